// File: rtl/cpu6502_pkg.sv
// ============================================================================
// Module   : cpu6502_pkg
// Purpose  : Shared 6502 core types and constants (sequencer states, vectors,
//            stack page).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu6502_pkg;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_PUSH_PCH = 4'd1,
    ST_PUSH_PCL = 4'd2,
    ST_PUSH_P   = 4'd3,
    ST_VEC_LO   = 4'd4,
    ST_VEC_HI   = 4'd5,
    ST_VEC_DONE = 4'd6,
    ST_PULL_P   = 4'd7,
    ST_PULL_PCL = 4'd8,
    ST_PULL_PCH = 4'd9,
    ST_RTI_DONE = 4'd10
  } seq_state_t;

  localparam logic [15:0] c_vec_nmi    = 16'hFFFA;
  localparam logic [15:0] c_vec_irq    = 16'hFFFE;
  localparam logic [7:0]  c_stack_page = 8'h01;

  // Stack accesses never leave page 0x01; the 8-bit argument wraps naturally.
  function automatic logic [15:0] stack_addr(input logic [7:0] sp_v);
    return {c_stack_page, sp_v};
  endfunction

endpackage

`default_nettype wire

// File: rtl/interrupt_sequencer_if.sv
// ============================================================================
// Module   : interrupt_sequencer_if
// Purpose  : Memory bus between the interrupt sequencer and system memory.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface interrupt_sequencer_if;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_we;
  logic [7:0]  mem_rdata;

  modport master (output mem_addr, output mem_wdata, output mem_we, input mem_rdata);
  modport slave  (input mem_addr, input mem_wdata, input mem_we, output mem_rdata);
endinterface

`default_nettype wire

// File: rtl/interrupt_sequencer_nmi_edge_detect.sv
// ============================================================================
// Module   : nmi_edge_detect
// Purpose  : One-cycle pulse on a falling edge of the active-low NMI line.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module nmi_edge_detect (
  input  wire logic clk,
  input  wire logic rst_n,
  input  wire logic nmi_n,
  output logic      pulse
);

  logic r_nmi_prev;

  always_ff @(posedge clk) begin
    if (!rst_n) r_nmi_prev <= 1'b1;
    else        r_nmi_prev <= nmi_n;
  end

  assign pulse = r_nmi_prev & ~nmi_n;

endmodule

`default_nettype wire

// File: rtl/interrupt_sequencer.sv
// ============================================================================
// Module   : interrupt_sequencer
// Purpose  : 6502 NMI/BRK/IRQ entry (push PC,P + vector fetch) and RTI exit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module interrupt_sequencer
  import cpu6502_pkg::*;
(
  input  wire logic        clk,
  input  wire logic        rst_n,
  input  wire logic [7:0]  status_reg,
  input  wire logic [15:0] pc,
  input  wire logic [7:0]  sp,
  input  wire logic        instr_boundary,
  input  wire logic        brk_req,
  input  wire logic        rti_req,
  input  wire logic        irq_n,
  input  wire logic        nmi_n,
  interrupt_sequencer_if.master bus,
  output logic             busy,
  output logic             done,
  output logic [15:0]      pc_out,
  output logic             pc_we,
  output logic [7:0]       sp_out,
  output logic             sp_we,
  output logic [7:0]       p_out,
  output logic             p_we,
  output logic             set_i
);

  seq_state_t  r_state, w_next;
  logic        r_nmi_pending;
  logic        w_nmi_edge;
  logic [15:0] r_pc;
  logic [7:0]  r_sp, r_p, r_lo, r_pull_p;
  logic        r_is_nmi, r_is_brk;

  logic        w_start, w_take_nmi, w_take_brk, w_take_irq, w_take_rti, w_take_any;
  logic [15:0] w_addr;
  logic [7:0]  w_wdata;
  logic        w_we;
  logic [15:0] w_vec;

  nmi_edge_detect u_nmi_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .nmi_n (nmi_n),
    .pulse (w_nmi_edge)
  );

  assign w_start    = (r_state == ST_IDLE) && instr_boundary;
  assign w_take_nmi = w_start && r_nmi_pending;
  assign w_take_brk = w_start && !r_nmi_pending && brk_req;
  assign w_take_irq = w_start && !r_nmi_pending && !brk_req && !irq_n && !status_reg[2];
  assign w_take_rti = w_start && !r_nmi_pending && !brk_req && !(!irq_n && !status_reg[2])
                      && rti_req;
  assign w_take_any = w_take_nmi || w_take_brk || w_take_irq;
  assign w_vec      = r_is_nmi ? c_vec_nmi : c_vec_irq;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_nmi_pending <= 1'b0;
      r_pc          <= 16'h0000;
      r_sp          <= 8'h00;
      r_p           <= 8'h00;
      r_lo          <= 8'h00;
      r_pull_p      <= 8'h00;
      r_is_nmi      <= 1'b0;
      r_is_brk      <= 1'b0;
    end else begin
      r_state <= w_next;
      // A fresh edge in the same cycle an NMI starts is a new NMI and must survive.
      if (w_nmi_edge)      r_nmi_pending <= 1'b1;
      else if (w_take_nmi) r_nmi_pending <= 1'b0;
      if (w_take_any || w_take_rti) begin
        r_pc     <= pc;
        r_sp     <= sp;
        r_p      <= status_reg;
        r_is_nmi <= w_take_nmi;
        r_is_brk <= w_take_brk;
      end
      if (r_state == ST_VEC_HI || r_state == ST_PULL_PCH) r_lo <= bus.mem_rdata;
      if (r_state == ST_PULL_PCL) r_pull_p <= bus.mem_rdata;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_take_any)      w_next = ST_PUSH_PCH;
        else if (w_take_rti) w_next = ST_PULL_P;
      end
      ST_PUSH_PCH: w_next = ST_PUSH_PCL;
      ST_PUSH_PCL: w_next = ST_PUSH_P;
      ST_PUSH_P:   w_next = ST_VEC_LO;
      ST_VEC_LO:   w_next = ST_VEC_HI;
      ST_VEC_HI:   w_next = ST_VEC_DONE;
      ST_VEC_DONE: w_next = ST_IDLE;
      ST_PULL_P:   w_next = ST_PULL_PCL;
      ST_PULL_PCL: w_next = ST_PULL_PCH;
      ST_PULL_PCH: w_next = ST_RTI_DONE;
      ST_RTI_DONE: w_next = ST_IDLE;
      default:     w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_addr  = 16'h0000;
    w_wdata = 8'h00;
    w_we    = 1'b0;
    busy    = (r_state != ST_IDLE);
    done    = 1'b0;
    pc_out  = 16'h0000;
    pc_we   = 1'b0;
    sp_out  = 8'h00;
    sp_we   = 1'b0;
    p_out   = 8'h00;
    p_we    = 1'b0;
    set_i   = 1'b0;
    case (r_state)
      ST_PUSH_PCH: begin
        w_addr  = stack_addr(r_sp);
        w_wdata = r_pc[15:8];
        w_we    = 1'b1;
      end
      ST_PUSH_PCL: begin
        w_addr  = stack_addr(r_sp - 8'd1);
        w_wdata = r_pc[7:0];
        w_we    = 1'b1;
      end
      ST_PUSH_P: begin
        w_addr  = stack_addr(r_sp - 8'd2);
        w_wdata = {r_p[7:6], 1'b1, r_is_brk, r_p[3:0]};
        w_we    = 1'b1;
      end
      ST_VEC_LO: w_addr = w_vec;
      ST_VEC_HI: w_addr = w_vec + 16'd1;
      ST_VEC_DONE: begin
        pc_out = {bus.mem_rdata, r_lo};
        pc_we  = 1'b1;
        sp_out = r_sp - 8'd3;
        sp_we  = 1'b1;
        set_i  = 1'b1;
        done   = 1'b1;
      end
      ST_PULL_P:   w_addr = stack_addr(r_sp + 8'd1);
      ST_PULL_PCL: w_addr = stack_addr(r_sp + 8'd2);
      ST_PULL_PCH: w_addr = stack_addr(r_sp + 8'd3);
      ST_RTI_DONE: begin
        p_out  = {r_pull_p[7:6], 2'b10, r_pull_p[3:0]};
        p_we   = 1'b1;
        pc_out = {bus.mem_rdata, r_lo};
        pc_we  = 1'b1;
        sp_out = r_sp + 8'd3;
        sp_we  = 1'b1;
        done   = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.mem_addr  = w_addr;
  assign bus.mem_wdata = w_wdata;
  assign bus.mem_we    = w_we;

endmodule

`default_nettype wire

// File: tb/tb_interrupt_sequencer.sv
// ============================================================================
// Module   : tb_interrupt_sequencer
// Purpose  : Self-checking bench: directed and random interrupt/RTI sequences
//            against a behavioural stack/vector model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_interrupt_sequencer;

  localparam int K_IRQ = 0;
  localparam int K_BRK = 1;
  localparam int K_NMI = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  status_reg, sp;
  logic [15:0] pc;
  logic        instr_boundary, brk_req, rti_req, irq_n, nmi_n;
  logic        busy, done, pc_we, sp_we, p_we, set_i;
  logic [15:0] pc_out;
  logic [7:0]  sp_out, p_out;

  logic [7:0]  mem [0:65535];
  int          n_err = 0;
  int          n_chk = 0;

  interrupt_sequencer_if bus ();

  interrupt_sequencer dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .status_reg     (status_reg),
    .pc             (pc),
    .sp             (sp),
    .instr_boundary (instr_boundary),
    .brk_req        (brk_req),
    .rti_req        (rti_req),
    .irq_n          (irq_n),
    .nmi_n          (nmi_n),
    .bus            (bus.master),
    .busy           (busy),
    .done           (done),
    .pc_out         (pc_out),
    .pc_we          (pc_we),
    .sp_out         (sp_out),
    .sp_we          (sp_we),
    .p_out          (p_out),
    .p_we           (p_we),
    .set_i          (set_i)
  );

  always #5 clk = ~clk;

  // Synchronous memory: read data for an address appears one cycle later.
  always @(posedge clk) begin
    if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
    bus.mem_rdata <= mem[bus.mem_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Inputs wander during a sequence; the sequencer must ignore them.
  task automatic scramble();
    pc             = 16'($urandom);
    sp             = 8'($urandom);
    status_reg     = 8'($urandom);
    instr_boundary = 1'b0;
    brk_req        = 1'b0;
    rti_req        = 1'b0;
    irq_n          = 1'b1;
  endtask

  function automatic logic [15:0] stk(input logic [7:0] s, input int off);
    return 16'(256 + ((int'(s) + off) & 255));
  endfunction

  task automatic run_int(input int kind, input logic [15:0] pc_v, input logic [7:0] sp_v,
                         input logic [7:0] p_v, input logic [15:0] target, input bit mid_nmi);
    logic [15:0] vec;
    logic [7:0]  exp_p;
    logic [15:0] exp_addr [1:5];
    logic [7:0]  exp_data [1:3];
    string       t;
    vec   = (kind == K_NMI) ? 16'hFFFA : 16'hFFFE;
    exp_p = (kind == K_BRK) ? (p_v | 8'h30) : ((p_v | 8'h20) & 8'hEF);
    mem[vec]         = target[7:0];
    mem[vec + 16'd1] = target[15:8];
    exp_addr[1] = stk(sp_v, 0);
    exp_addr[2] = stk(sp_v, -1);
    exp_addr[3] = stk(sp_v, -2);
    exp_addr[4] = vec;
    exp_addr[5] = vec + 16'd1;
    exp_data[1] = pc_v[15:8];
    exp_data[2] = pc_v[7:0];
    exp_data[3] = exp_p;
    pc = pc_v; sp = sp_v; status_reg = p_v; instr_boundary = 1'b1;
    brk_req = (kind == K_BRK) ? 1'b1 : ((kind == K_NMI) ? 1'($urandom_range(0, 1)) : 1'b0);
    irq_n   = (kind == K_IRQ) ? 1'b0 : 1'($urandom_range(0, 1));
    rti_req = 1'($urandom_range(0, 1));
    tick();
    scramble();
    for (int i = 1; i <= 6; i++) begin
      t = $sformatf("int%0d_c%0d", kind, i);
      chk({t, "_busy"}, 32'(busy), 32'd1);
      chk({t, "_we"}, 32'(bus.mem_we), 32'(i <= 3));
      if (i <= 5) chk({t, "_addr"}, 32'(bus.mem_addr), 32'(exp_addr[i]));
      if (i <= 3) chk({t, "_wdata"}, 32'(bus.mem_wdata), 32'(exp_data[i]));
      chk({t, "_pulses"}, {28'd0, done, pc_we, sp_we, set_i}, (i == 6) ? 32'hF : 32'h0);
      chk({t, "_p_we"}, 32'(p_we), 32'd0);
      if (i == 6) begin
        chk({t, "_pc_out"}, 32'(pc_out), 32'(target));
        chk({t, "_sp_out"}, 32'(sp_out), 32'((int'(sp_v) + 253) & 255));
      end
      if (mid_nmi && i == 3) nmi_n = 1'b0;
      tick();
      scramble();
      if (mid_nmi && i == 4) nmi_n = 1'b1;
    end
    chk($sformatf("int%0d_idle_busy", kind), 32'(busy), 32'd0);
    chk($sformatf("int%0d_idle_done", kind), 32'(done), 32'd0);
    chk($sformatf("int%0d_mem_pch", kind), 32'(mem[stk(sp_v, 0)]), 32'(pc_v[15:8]));
    chk($sformatf("int%0d_mem_pcl", kind), 32'(mem[stk(sp_v, -1)]), 32'(pc_v[7:0]));
    chk($sformatf("int%0d_mem_p", kind), 32'(mem[stk(sp_v, -2)]), 32'(exp_p));
  endtask

  task automatic run_rti(input logic [7:0] sp_v, input logic [7:0] b_p,
                         input logic [7:0] b_pcl, input logic [7:0] b_pch);
    string t;
    mem[stk(sp_v, 1)] = b_p;
    mem[stk(sp_v, 2)] = b_pcl;
    mem[stk(sp_v, 3)] = b_pch;
    sp = sp_v; pc = 16'($urandom); status_reg = 8'($urandom);
    irq_n = 1'b1; brk_req = 1'b0; rti_req = 1'b1; instr_boundary = 1'b1;
    tick();
    scramble();
    for (int i = 1; i <= 4; i++) begin
      t = $sformatf("rti_c%0d", i);
      chk({t, "_busy"}, 32'(busy), 32'd1);
      chk({t, "_we"}, 32'(bus.mem_we), 32'd0);
      if (i <= 3) chk({t, "_addr"}, 32'(bus.mem_addr), 32'(stk(sp_v, i)));
      chk({t, "_pulses"}, {27'd0, done, pc_we, sp_we, p_we, set_i}, (i == 4) ? 32'h1E : 32'h0);
      if (i == 4) begin
        chk({t, "_p_out"}, 32'(p_out), 32'((b_p | 8'h20) & 8'hEF));
        chk({t, "_pc_out"}, 32'(pc_out), {16'd0, b_pch, b_pcl});
        chk({t, "_sp_out"}, 32'(sp_out), 32'((int'(sp_v) + 3) & 255));
      end
      tick();
      scramble();
    end
    chk("rti_idle_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int          kind;
    logic [7:0]  pv;
    for (int a = 0; a < 65536; a++) mem[a] = 8'h00;
    rst_n = 1'b0; nmi_n = 1'b1;
    scramble();
    tick(); tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_addr", 32'(bus.mem_addr), 32'd0);
    chk("rst_outs", {25'd0, bus.mem_we, done, pc_we, sp_we, p_we, set_i, 1'b0}, 32'd0);
    rst_n = 1'b1;
    tick();
    chk("idle_busy", 32'(busy), 32'd0);

    // IRQ entry, BRK entry with B flag, NMI raised mid-IRQ then serviced first.
    run_int(K_IRQ, 16'h1234, 8'hFD, 8'h20, 16'h8000, 1'b0);
    run_int(K_BRK, 16'h4567, 8'hF0, 8'h21, 16'h9ABC, 1'b0);
    run_int(K_IRQ, 16'h2222, 8'hE0, 8'h00, 16'h7777, 1'b1);
    run_int(K_NMI, 16'h3333, 8'hD0, 8'h10, 16'hC0DE, 1'b0);

    // Masked IRQ starts nothing.
    status_reg = 8'h04; irq_n = 1'b0; instr_boundary = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("masked_irq_%0d", i), 32'(busy), 32'd0);
    end
    scramble();

    run_rti(8'hFA, 8'hFF, 8'h34, 8'h12);
    run_int(K_IRQ, 16'hABCD, 8'h01, 8'h00, 16'h1000, 1'b0);
    run_rti(8'hFE, 8'h00, 8'h55, 8'h66);

    // Reset asserted while in PUSH_PCL.
    mem[16'h017E] = 8'hA5;
    pc = 16'hBEEF; sp = 8'h80; status_reg = 8'h00; irq_n = 1'b0; instr_boundary = 1'b1;
    tick();
    scramble();
    chk("abort_c1_addr", 32'(bus.mem_addr), 32'h0180);
    tick();
    chk("abort_c2_addr", 32'(bus.mem_addr), 32'h017F);
    rst_n = 1'b0;
    tick();
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_outs", {27'd0, bus.mem_we, done, pc_we, sp_we, set_i}, 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("abort_after_%0d", i), {28'd0, busy, bus.mem_we, pc_we, sp_we}, 32'd0);
    end
    chk("abort_mem_pch", 32'(mem[16'h0180]), 32'hBE);
    chk("abort_mem_p", 32'(mem[16'h017E]), 32'hA5);

    // Random sequences.
    for (int n = 0; n < 12; n++) begin
      kind = int'($urandom_range(0, 2));
      if (kind == K_NMI) begin
        nmi_n = 1'b0; tick(); nmi_n = 1'b1; tick();
      end
      pv = 8'($urandom) & ((kind == K_IRQ) ? 8'hFB : 8'hFF);
      run_int(kind, 16'($urandom), 8'($urandom), pv, 16'($urandom), 1'b0);
      run_rti(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/interrupt_sequencer.md
INTERRUPT_SEQUENCER -- requirements
Module: interrupt_sequencer

Interface
REQ-001 The module SHALL use one clock and a synchronous, active-low reset; ports are listed in the order below.
REQ-002 clk  in  1  system clock; all state changes occur on its rising edge.
REQ-003 rst_n  in  1  synchronous active-low reset.
REQ-004 status_reg  in  8  current P flags (NV-BDIZC), sampled for the push and for the I mask.
REQ-005 pc  in  16  return address to push.
REQ-006 sp  in  8  current stack pointer.
REQ-007 instr_boundary  in  1  high when the core may start a sequence.
REQ-008 brk_req, rti_req  in  1 each  single-cycle requests from the decoder.
REQ-009 irq_n, nmi_n  in  1 each  external interrupt lines, active-low.
REQ-010 mem_addr  out  16;  mem_wdata  out  8;  mem_we  out  1;  mem_rdata  in  8.
  - mem_rdata is valid one cycle after mem_addr is presented.
REQ-011 busy  out  1;  done  out  1  (single-cycle pulse).
REQ-012 pc_out  out  16 with pc_we  out  1;  sp_out  out  8 with sp_we  out  1;  p_out  out  8 with p_we  out  1;  set_i  out  1.

Function
REQ-013 NMI SHALL be detected on a falling edge of nmi_n and latched as nmi_pending.
  - nmi_pending clears only when an NMI sequence starts.
  - An edge arriving while busy stays pending.
REQ-014 Start condition: state IDLE and instr_boundary=1.
  - Priority: nmi_pending > brk_req > IRQ (irq_n=0 and status_reg[2]=0) > rti_req.
  - Requests not accepted in that cycle are dropped, except nmi_pending.
REQ-015 Interrupt path (NMI/BRK/IRQ) states: IDLE -> PUSH_PCH -> PUSH_PCL -> PUSH_P -> VEC_LO -> VEC_HI -> VEC_DONE -> IDLE, one cycle each; busy=1 outside IDLE.
REQ-016 Push addresses:
  - PUSH_PCH: mem_addr 0x0100|sp, mem_wdata pc[15:8].
  - PUSH_PCL: mem_addr 0x0100|(sp-1), mem_wdata pc[7:0].
  - PUSH_P: mem_addr 0x0100|(sp-2), mem_wdata status_reg with bit5=1 and bit4=1 for BRK, 0 otherwise.
  - mem_we=1 in these states.
  - All SP arithmetic is modulo 256, staying in page 0x01.
REQ-017 Vector fetch: VEC_LO presents vector base (NMI 0xFFFA, IRQ/BRK 0xFFFE); VEC_HI presents base+1 and captures the low byte; VEC_DONE captures the high byte.
REQ-018 In VEC_DONE, single-cycle pulses:
  - pc_we with pc_out={hi,lo}.
  - sp_we with sp_out=sp-3.
  - set_i=1.
  - done=1.
REQ-019 RTI path states: IDLE -> PULL_P -> PULL_PCL -> PULL_PCH -> RTI_DONE -> IDLE.
  - Addresses 0x0100|(sp+1), (sp+2), (sp+3) are presented in the first three states, mem_we=0.
  - Each byte is captured one cycle later.
REQ-020 In RTI_DONE, single-cycle pulses:
  - p_we with p_out = pulled byte, bit5 forced 1 and bit4 forced 0.
  - pc_we with pc_out={PCH,PCL}.
  - sp_we with sp_out=sp+3.
  - done=1.
  - set_i=0.
REQ-021 pc, sp and status_reg SHALL be latched at sequence start; later input changes do not affect the sequence.
REQ-022 Outside the states above, mem_we, pc_we, sp_we, p_we, set_i and done SHALL be 0.

Reset
REQ-023 While rst_n=0 at a clock edge, the state SHALL become IDLE and nmi_pending SHALL clear.
  - Internal nmi_n history register set to 1.
  - All outputs 0; mem_addr 0x0000.
REQ-024 Reset mid-sequence SHALL abort with no further writes or pulses.
  - Bytes already pushed remain in memory; SP and PC are not updated.

Structure
REQ-025 The state enum, vector constants (0xFFFA, 0xFFFE) and stack page (0x01) SHALL live in the shared cpu6502_pkg.
REQ-026 NMI falling-edge detection SHALL be a sub-module, nmi_edge_detect (clk, rst_n, nmi_n -> pulse), with set/clear of nmi_pending in the parent.

Verification
REQ-027 IRQ:
  - Stimulus: status_reg=0x20, sp=0xFD, pc=0x1234, irq_n=0, instr_boundary=1; memory FFFE=0x00, FFFF=0x80.
  - Response: writes 01FD=0x12, 01FC=0x34, 01FB=0x20; pc_out=0x8000, sp_out=0xFA, set_i=1; done in the 6th busy cycle.
REQ-028 BRK:
  - Stimulus: brk_req, status_reg=0x21.
  - Response: pushed P=0x31; vector read from 0xFFFE.
REQ-029 NMI during an IRQ sequence:
  - Stimulus: falling edge of nmi_n mid-sequence.
  - Response: next boundary starts NMI and reads 0xFFFA/0xFFFB.
  - Also: irq_n=0 with status_reg[2]=1 starts nothing.
REQ-030 RTI:
  - Stimulus: sp=0xFA; memory 01FB=0xFF, 01FC=0x34, 01FD=0x12.
  - Response: p_out=0xEF, pc_out=0x1234, sp_out=0xFD.
REQ-031 SP wrap:
  - Interrupt with sp=0x01 pushes to 0x0101, 0x0100, 0x01FF; sp_out=0xFE.
  - RTI with sp=0xFE reads 0x01FF, 0x0100, 0x0101; sp_out=0x01.
REQ-032 Reset abort:
  - Stimulus: rst_n=0 in PUSH_PCL.
  - Response: next cycle busy=0, no further mem_we, no pc_we or sp_we pulse.
